// File: rtl/gated_clock_ctrl_if.sv
// Control/config/status bundle between the Gated_Clock register bank and the
// clock-enable sequencer.
interface gated_clock_ctrl_if #(
   parameter int DIV_WIDTH = 16,
   parameter int CNT_WIDTH = 32
);
   logic                 ctrl_start;
   logic                 ctrl_stop;
   logic                 ctrl_mode;
   logic [DIV_WIDTH-1:0] div_value;
   logic [CNT_WIDTH-1:0] pulse_count;
   logic                 clk_en;
   logic                 busy;
   logic                 done;
   logic                 err_cfg;
   logic [CNT_WIDTH-1:0] pulses_out;

   modport master (
      output ctrl_start, ctrl_stop, ctrl_mode, div_value, pulse_count,
      input  clk_en, busy, done, err_cfg, pulses_out
   );

   modport slave (
      input  ctrl_start, ctrl_stop, ctrl_mode, div_value, pulse_count,
      output clk_en, busy, done, err_cfg, pulses_out
   );
endinterface

// File: rtl/gated_clock_ctrl.sv
// Clock-enable sequencer: continuous divided enable or counted burst of
// enable pulses, with a flop-driven clk_en for a downstream BUFGCE.
module gated_clock_ctrl #(
   parameter int DIV_WIDTH = 16,
   parameter int CNT_WIDTH = 32
) (
   input logic            ACLK,
   input logic            ARESET,
   gated_clock_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_n;
   logic                 clk_en_q, clk_en_n;
   logic                 busy_q, busy_n;
   logic                 done_q, done_n;
   logic                 err_q, err_n;
   logic                 mode_q, mode_n;
   logic [DIV_WIDTH-1:0] per_q, per_n, per_in;
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_n;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
   logic [CNT_WIDTH-1:0] pulses_q, pulses_n, pulses_inc;
   logic                 start_ok;

   // A zero divider behaves like a divider of one.
   assign per_in     = (bus.div_value == '0) ? DIV_WIDTH'(1) : bus.div_value;
   assign pulses_inc = pulses_q + CNT_WIDTH'(1);
   assign start_ok   = bus.ctrl_start & ~bus.ctrl_stop;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         clk_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         mode_q    <= 1'b0;
         per_q     <= '0;
         div_cnt_q <= '0;
         cnt_q     <= '0;
         pulses_q  <= '0;
      end else begin
         state_q   <= state_n;
         clk_en_q  <= clk_en_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
         err_q     <= err_n;
         mode_q    <= mode_n;
         per_q     <= per_n;
         div_cnt_q <= div_cnt_n;
         cnt_q     <= cnt_n;
         pulses_q  <= pulses_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      clk_en_n  = 1'b0;
      done_n    = 1'b0;
      err_n     = 1'b0;
      mode_n    = mode_q;
      per_n     = per_q;
      div_cnt_n = div_cnt_q;
      cnt_n     = cnt_q;
      pulses_n  = pulses_q;

      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               if (bus.ctrl_mode && bus.pulse_count == '0) begin
                  err_n = 1'b1;
               end else begin
                  mode_n    = bus.ctrl_mode;
                  per_n     = per_in;
                  cnt_n     = bus.pulse_count;
                  clk_en_n  = 1'b1;
                  pulses_n  = CNT_WIDTH'(1);
                  div_cnt_n = per_in - DIV_WIDTH'(1);
                  state_n   = (bus.ctrl_mode && bus.pulse_count == CNT_WIDTH'(1)) ? DONE : RUN;
               end
            end
         end
         RUN: begin
            if (bus.ctrl_stop) begin
               state_n = IDLE;
            end else if (div_cnt_q != '0) begin
               div_cnt_n = div_cnt_q - DIV_WIDTH'(1);
            end else begin
               clk_en_n  = 1'b1;
               div_cnt_n = per_q - DIV_WIDTH'(1);
               // Counted bursts never exceed the latched count, so only continuous mode can saturate.
               pulses_n  = (!mode_q && pulses_q == '1) ? pulses_q : pulses_inc;
               if (mode_q && pulses_inc == cnt_q)
                  state_n = DONE;
            end
         end
         DONE: begin
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n == RUN) || (state_n == DONE);
   end

   assign bus.clk_en     = clk_en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err_cfg    = err_q;
   assign bus.pulses_out = pulses_q;
endmodule

// File: doc/gated_clock_ctrl.md
Name: gated_clock_ctrl

Overview:
- Clock-enable sequencer behind the Gated_Clock AXI4-Lite register bank.
- Consumes the decoded control and config register fields: start/stop strobes, mode, divider and pulse count.
- Produces a registered, glitch-free clock-enable (clk_en) for a downstream BUFGCE, plus status fields the register bank reads back.
- Supports two modes: continuous divided enable, and a counted burst of enable pulses.

Parameters:
DIV_WIDTH, 16, width of divider field; enable period in ACLK cycles
CNT_WIDTH, 32, width of burst pulse count and of pulse counter status

Ports:
ACLK  in  1  system clock; all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
ctrl_start  in  1  one-cycle strobe from control register write (bit 0)
ctrl_stop  in  1  one-cycle strobe from control register write (bit 1)
ctrl_mode  in  1  0 = continuous, 1 = counted burst; sampled on accepted start
div_value  in  DIV_WIDTH  enable period; sampled on accepted start
pulse_count  in  CNT_WIDTH  burst length in counted mode; sampled on accepted start
clk_en  out  1  registered clock enable to BUFGCE CE
busy  out  1  registered; high while sequencer is RUN or DONE
done  out  1  registered one-cycle pulse when a counted burst completes
err_cfg  out  1  registered one-cycle pulse on rejected start
pulses_out  out  CNT_WIDTH  number of clk_en pulses issued since last accepted start

Behaviour:
- Reset: ARESET high forces all of the following immediately, independent of ACLK:
  - state = IDLE; clk_en, busy, done, err_cfg = 0.
  - pulses_out = 0; internal div_cnt = 0; latched config = 0.
- Reset mid-burst kills clk_en with no completing pulse and no done.
- States: IDLE, RUN, DONE.
- Period P = div_value if div_value != 0, else 1. div_value = 0 and div_value = 1 both give a continuous enable.
- IDLE:
  - Start accepted when ctrl_start = 1 and ctrl_stop = 0.
  - Counted mode with pulse_count = 0: start is rejected. err_cfg pulses in the next cycle, state stays IDLE, pulses_out is unchanged.
  - Otherwise at the accepting edge: latch mode/P/count, clk_en <= 1, pulses_out <= 1, div_cnt <= P-1, busy <= 1.
  - Counted mode with count = 1: state goes directly to DONE. All other starts go to RUN.
  - ctrl_start and ctrl_stop together in IDLE: ignored, no error.
  - ctrl_stop alone in IDLE: no effect.
- RUN:
  - If ctrl_stop = 1: at that edge state <= IDLE, clk_en <= 0, busy <= 0, no done; pulses_out holds.
  - Otherwise, while div_cnt != 0: div_cnt decrements and clk_en <= 0.
  - When div_cnt = 0: clk_en <= 1, div_cnt <= P-1, pulses_out increments.
  - With P = 1, clk_en stays high every cycle.
  - Counted mode: the edge that makes pulses_out equal the latched count moves state to DONE.
  - Continuous mode: pulses_out saturates at all-ones; no wrap.
  - ctrl_start in RUN is ignored.
  - Config inputs changing during RUN have no effect; latched values are used.
- DONE (exactly one cycle):
  - At the next edge: clk_en <= 0, done <= 1, busy <= 0, state <= IDLE.
  - ctrl_stop arriving in DONE is ignored; the burst completes normally and done still pulses.
- done and err_cfg are single-cycle pulses; they clear at the following edge.
- clk_en is driven only from a flop. The block never gates ACLK itself.
- pulses_out holds its value in IDLE until the next accepted start.

Test Plan:
- Reset: assert ARESET mid-RUN with clk_en = 1 -> clk_en, busy, pulses_out = 0 asynchronously, before the next ACLK edge.
- Counted burst: mode = 1, div = 3, count = 4, start accepted at edge E0 ->
  - clk_en high in cycles 1, 4, 7, 10 only.
  - busy high in cycles 1-10; done high in cycle 11 only.
  - pulses_out = 4 and holds.
- Continuous: mode = 0, div = 0, then stop at cycle 6 ->
  - clk_en high cycles 1-6 (the stop edge at E6 clears it from cycle 7).
  - pulses_out = 6; done never asserted; busy = 0 from cycle 7.
- Rejects:
  - mode = 1, count = 0, start -> err_cfg high cycle 1 only; busy stays 0; pulses_out unchanged.
  - start + stop same cycle in IDLE -> no state change, no err_cfg.
- Start during RUN: div = 2, count = 3, second start at cycle 2 with div = 5 -> ignored; clk_en at cycles 1, 3, 5; done at cycle 6.
- Saturation: force pulses_out near all-ones via CNT_WIDTH = 4, continuous, div = 1, run 20 cycles -> pulses_out sticks at 15.
